ps2_frame_rx: RTL and testbench
===============================

Name: ps2_frame_rx

Overview:
Parametrised PS/2 device-to-host frame receiver. It replaces the free-running bit-count shift register with a system-clock-domain receiver:
- input synchronisation and falling-edge detect on ps2_clk
- start/parity/stop checking and an inactivity timeout
- valid/ready output handshake with overrun detection

It sits between the PS/2 pins and the keyboard scan-code decoder.

Parameters:
- DATA_W, 8: payload bits per frame, sent LSB first.
- PARITY_ODD, 1: 1 = odd parity expected, 0 = even parity expected.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data (minimum 2).
- TIMEOUT_CYC, 5000: clk cycles with no ps2_clk falling edge that abort a frame in progress.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ps2_clk, in, 1: raw PS/2 clock pin, asynchronous to clk.
- ps2_data, in, 1: raw PS/2 data pin, asynchronous to clk.
- rx_ready, in, 1: consumer accepts rx_data when rx_valid && rx_ready.
- rx_valid, out, 1: held data word is valid.
- rx_data, out, DATA_W: received payload.
- parity_err, out, 1: one-cycle pulse, frame dropped on parity mismatch.
- frame_err, out, 1: one-cycle pulse, frame dropped on bad stop bit or timeout.
- overrun, out, 1: one-cycle pulse, good frame dropped because the output was still occupied.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, rx_data 0, FSM IDLE, bit counter 0, timeout counter 0, synchroniser flops 1 (line idle-high).
- Synchronisation:
  - Both pins pass through SYNC_STAGES flops.
  - fall = previous synced clk 1 and current synced clk 0.
  - The data bit is taken from synced ps2_data on the same cycle as fall.
- FSM states: IDLE, DATA, PARITY, STOP. Every bit sample happens only on a fall cycle.
- IDLE:
  - fall with data 0 -> DATA, clear shift register and bit counter.
  - fall with data 1 -> ignored, stay IDLE, no error.
- DATA:
  - Shift right, inserting the new bit at the MSB, so the first bit ends up at bit 0.
  - Increment the counter.
  - After the DATA_W-th bit -> PARITY.
- PARITY: store the bit, go to STOP.
- STOP (on fall), one outcome per frame:
  - Parity check: xor of payload and parity bit equals PARITY_ODD; otherwise the frame fails parity.
  - Stop bit 0 -> frame_err pulse.
  - Else parity bad -> parity_err pulse.
  - Else good frame.
  - Then -> IDLE in all cases.
- Good frame, output free or being accepted this cycle (rx_valid=0, or rx_valid && rx_ready):
  - Next cycle rx_valid=1 and rx_data=payload.
  - Latency: rx_valid rises 1 clk after the stop-bit fall cycle.
- Good frame, output occupied and not accepted this cycle:
  - overrun pulses.
  - New payload discarded; old rx_data and rx_valid held.
- Handshake:
  - rx_valid stays high and rx_data stable until the rx_valid && rx_ready cycle.
  - rx_valid clears the following cycle unless a new good frame loads that same cycle, in which case it stays 1 with the new data.
- Timeout:
  - Counter resets on every fall and while in IDLE; increments otherwise.
  - Reaching TIMEOUT_CYC in a non-IDLE state -> IDLE plus frame_err pulse.
  - Timeout takes priority over a coincident fall.
- Error pulses are mutually exclusive and last exactly 1 cycle.
- Reset mid-frame aborts the frame immediately with no error pulse and drops any held word.
- Widths:
  - Bit counter $clog2(DATA_W+1).
  - Timeout counter $clog2(TIMEOUT_CYC+1); saturates, never wraps.

Decomposition:
- Package ps2_pkg:
  - FSM state enum.
  - PS2_IDLE_LEVEL constant (1).
  - Parity function: odd/even of a vector.
- Sub-module ps2_sync_edge: SYNC_STAGES synchroniser for both pins, with outputs clk_fall and data_s. Reused later by the host-to-device transmitter.

Test Plan:
Bench drives the PS/2 pins with a 100-clk bit period; each frame is start, DATA_W bits LSB first, parity, stop.
1. Good frame: frame 0x1C with parity 0 (odd), rx_ready=1 -> rx_valid high exactly 1 cycle, rx_data=0x1C, no error pulses, busy low after STOP.
2. Parity error: frame 0x1C with parity 1 -> parity_err single pulse, rx_valid stays 0.
3. Frame error: frame 0xF0 with correct parity and stop=0 -> frame_err pulse, rx_valid stays 0.
4. Timeout: start plus 4 data bits, then the clock stops -> frame_err pulses TIMEOUT_CYC cycles after the last fall, busy drops. A following good 0x5A frame is received correctly.
5. Overrun then back-to-back: rx_ready=0, frames 0x1C then 0x32 -> rx_data stays 0x1C and overrun pulses once. Raise rx_ready the cycle the third frame 0x45 completes -> rx_valid stays high with rx_data=0x45.
6. Reset mid-frame: assert reset during data bit 3 -> all outputs 0 immediately, no error pulses. Next frame 0x29 is received normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive/transmit blocks.
// Line idle level, frame FSM states and a parity helper.
package ps2_pkg;

  localparam logic PS2_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } ps2_state_t;

  // Zero-extend narrower vectors; the extra zeros do not change the xor.
  function automatic logic xor_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the PS/2 clock and data pins into the clk domain
// and flags falling edges of the synchronised PS/2 clock.
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall,
  output logic data_s
);

  logic [SYNC_STAGES-1:0] cs;
  logic [SYNC_STAGES-1:0] ds;
  logic                   cprev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs    <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      ds    <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      cprev <= PS2_IDLE_LEVEL;
    end else begin
      cs    <= {cs[SYNC_STAGES-2:0], ps2_clk};
      ds    <= {ds[SYNC_STAGES-2:0], ps2_data};
      cprev <= cs[SYNC_STAGES-1];
    end
  end

  assign clk_fall = cprev & ~cs[SYNC_STAGES-1];
  assign data_s   = ds[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start/data/parity/stop framing,
// inactivity timeout and a valid/ready output with overrun flag.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_ODD  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic              fall;
  logic              din;
  ps2_state_t        state;
  logic [CW-1:0]     bcnt;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tinc;
  logic [DATA_W-1:0] sh;
  logic              par;
  logic              tout;
  logic              good_par;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .clk_fall(fall),
    .data_s  (din)
  );

  assign tinc = (tcnt == TW'(TIMEOUT_CYC)) ? tcnt : tcnt + 1'b1;
  assign tout = (state != S_IDLE) && (tinc == TW'(TIMEOUT_CYC));
  assign good_par = (xor_par(64'(sh)) ^ par) == 1'(PARITY_ODD);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bcnt       <= '0;
      tcnt       <= '0;
      sh         <= '0;
      par        <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      if (state == S_IDLE || fall)
        tcnt <= '0;
      else
        tcnt <= tinc;
      // A stalled line wins over a fall arriving on the same cycle.
      if (tout) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end else if (fall) begin
        unique case (state)
          S_IDLE: begin
            if (!din) begin
              state <= S_DATA;
              sh    <= '0;
              bcnt  <= '0;
            end
          end
          S_DATA: begin
            sh   <= {din, sh[DATA_W-1:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == CW'(DATA_W - 1))
              state <= S_PARITY;
          end
          S_PARITY: begin
            par   <= din;
            state <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (!din)
              frame_err <= 1'b1;
            else if (!good_par)
              parity_err <= 1'b1;
            else if (!rx_valid || rx_ready) begin
              rx_valid <= 1'b1;
              rx_data  <= sh;
            end else
              overrun <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed plus randomized frame-level checks of ps2_frame_rx
// against a pin-level PS/2 driver and a frame outcome model.
module tb_ps2_frame_rx;

  localparam int DATA_W      = 8;
  localparam int PARITY_ODD  = 1;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 5000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic              rx_ready = 1'b0;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  ps2_frame_rx #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_ready  (rx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;

  int n_acc = 0, n_vcyc = 0, n_perr = 0, n_ferr = 0, n_ovr = 0, n_multi = 0;
  logic [DATA_W-1:0] last_acc = '0;
  int b_acc, b_vcyc, b_perr, b_ferr, b_ovr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        n_acc    = n_acc + 1;
        last_acc = rx_data;
      end
      if (rx_valid) n_vcyc = n_vcyc + 1;
      n_perr = n_perr + int'(parity_err);
      n_ferr = n_ferr + int'(frame_err);
      n_ovr  = n_ovr + int'(overrun);
      if (int'(parity_err) + int'(frame_err) + int'(overrun) > 1)
        n_multi = n_multi + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_acc  = n_acc;
    b_vcyc = n_vcyc;
    b_perr = n_perr;
    b_ferr = n_ferr;
    b_ovr  = n_ovr;
  endtask

  function automatic logic parbit(input logic [DATA_W-1:0] d);
    return logic'(($countones(d) % 2) != 0) ^ logic'(PARITY_ODD);
  endfunction

  // One 100-clk bit cell: data set while clk high, clk low for 50 clks.
  task automatic drive_bit(input logic b, input bit rdy_pulse);
    @(posedge clk);
    #1 ps2_data = b;
    repeat (24) @(posedge clk);
    #1 ps2_clk = 1'b0;
    fall_cyc = cyc;
    if (rdy_pulse) begin
      repeat (SYNC_STAGES) @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      repeat (47 - SYNC_STAGES) @(posedge clk);
    end else
      repeat (50) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (24) @(posedge clk);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit pflip,
                            input logic stopb, input int nbits,
                            input bit rdy_at_stop);
    logic [DATA_W+2:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) bits[i+1] = d[i];
    bits[DATA_W+1] = parbit(d) ^ logic'(pflip);
    bits[DATA_W+2] = stopb;
    for (int i = 0; i < nbits; i++)
      drive_bit(bits[i], rdy_at_stop && (i == DATA_W + 2));
    #1 ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    logic [DATA_W-1:0] d;
    int kind;
    int e_acc, e_perr, e_ferr;
    logic [DATA_W-1:0] e_last;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {parity_err, frame_err, overrun}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    // Good frame
    rx_ready = 1'b1;
    snap();
    send_frame(8'h1C, 0, 1'b1, DATA_W + 3, 0);
    @(negedge clk);
    chk("good_acc", n_acc - b_acc, 1);
    chk("good_data", last_acc, 8'h1C);
    chk("good_vcyc", n_vcyc - b_vcyc, 1);
    chk("good_errs", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    chk("good_busy", busy, 0);

    // Parity error
    snap();
    send_frame(8'h1C, 1, 1'b1, DATA_W + 3, 0);
    @(negedge clk);
    chk("par_perr", n_perr - b_perr, 1);
    chk("par_vcyc", n_vcyc - b_vcyc, 0);
    chk("par_ferr", n_ferr - b_ferr, 0);

    // Bad stop bit
    snap();
    send_frame(8'hF0, 0, 1'b0, DATA_W + 3, 0);
    @(negedge clk);
    chk("stop_ferr", n_ferr - b_ferr, 1);
    chk("stop_perr", n_perr - b_perr, 0);
    chk("stop_vcyc", n_vcyc - b_vcyc, 0);

    // Timeout after start + 4 data bits
    snap();
    send_frame(8'h5A, 0, 1'b1, 5, 0);
    chk("to_busy_mid", busy, 1);
    seen = 0;
    for (int i = 0; i < TIMEOUT_CYC + 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_err) seen = 1;
    end
    lat = cyc - fall_cyc;
    chk("to_seen", seen, 1);
    chk("to_latency_ok",
        (lat >= TIMEOUT_CYC) && (lat <= TIMEOUT_CYC + SYNC_STAGES + 2), 1);
    @(negedge clk);
    chk("to_busy", busy, 0);
    chk("to_ferr_cnt", n_ferr - b_ferr, 1);
    snap();
    send_frame(8'h5A, 0, 1'b1, DATA_W + 3, 0);
    @(negedge clk);
    chk("to_next_acc", n_acc - b_acc, 1);
    chk("to_next_data", last_acc, 8'h5A);

    // Overrun, then back-to-back accept and reload
    @(posedge clk);
    #1 rx_ready = 1'b0;
    snap();
    send_frame(8'h1C, 0, 1'b1, DATA_W + 3, 0);
    send_frame(8'h32, 0, 1'b1, DATA_W + 3, 0);
    @(negedge clk);
    chk("ovr_cnt", n_ovr - b_ovr, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h1C);
    chk("ovr_acc", n_acc - b_acc, 0);
    send_frame(8'h45, 0, 1'b1, DATA_W + 3, 1);
    @(negedge clk);
    chk("b2b_acc", n_acc - b_acc, 1);
    chk("b2b_old", last_acc, 8'h1C);
    chk("b2b_valid", rx_valid, 1);
    chk("b2b_data", rx_data, 8'h45);
    chk("b2b_ovr", n_ovr - b_ovr, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b2b_drain", last_acc, 8'h45);
    chk("b2b_empty", rx_valid, 0);

    // Reset mid-frame with a held word
    @(posedge clk);
    #1 rx_ready = 1'b0;
    send_frame(8'h77, 0, 1'b1, DATA_W + 3, 0);
    @(negedge clk);
    chk("mid_held", rx_valid, 1);
    snap();
    send_frame(8'h29, 0, 1'b1, 4, 0);
    @(posedge clk);
    #1 ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_valid", rx_valid, 0);
    chk("mid_data", rx_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_errs", {parity_err, frame_err, overrun}, 0);
    ps2_clk = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h29, 0, 1'b1, DATA_W + 3, 0);
    @(negedge clk);
    chk("mid_next_acc", n_acc - b_acc, 1);
    chk("mid_next_data", last_acc, 8'h29);
    chk("mid_no_err", (n_perr - b_perr) + (n_ferr - b_ferr), 0);

    // Randomized frames against the outcome model
    for (int k = 0; k < 8; k++) begin
      snap();
      d = DATA_W'($urandom);
      kind = int'($urandom_range(0, 3));
      e_acc = 0; e_perr = 0; e_ferr = 0; e_last = last_acc;
      if (kind == 3) e_ferr = 1;
      else if (kind == 2) e_perr = 1;
      else begin e_acc = 1; e_last = d; end
      send_frame(d, kind == 2, logic'(kind != 3), DATA_W + 3, 0);
      @(negedge clk);
      chk("rnd_acc", n_acc - b_acc, e_acc);
      chk("rnd_data", last_acc, e_last);
      chk("rnd_perr", n_perr - b_perr, e_perr);
      chk("rnd_ferr", n_ferr - b_ferr, e_ferr);
    end

    chk("excl_pulses", n_multi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
